// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/ifetch.sv
// Single-outstanding instruction fetch: one word per (memory latency + 2) cycles, redirect-aware.
// Define IFETCH_MISALIGN_CHECK_EN to trap fetches from non-word-aligned addresses in S_FAULT.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        pc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    state_e      state_q, state_d;
    logic [31:0] faddr_q, faddr_d;
    logic [31:0] pend_q, pend_d;
    logic        drop_q, drop_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        launch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            faddr_q <= RESET_PC;
            pend_q  <= RESET_PC;
            drop_q  <= 1'b0;
            instr_q <= NOP;
            ipc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            faddr_q <= faddr_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        faddr_d = faddr_q;
        pend_d  = pend_q;
        drop_d  = drop_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        launch  = 1'b0;
        case (state_q)
            S_IDLE: begin
                launch  = 1'b1;
                faddr_d = redirect_valid ? redirect_pc : pc;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    drop_d = 1'b0;
                    if (redirect_valid) begin
                        launch  = 1'b1;
                        faddr_d = redirect_pc;
                    end else if (drop_q) begin
                        launch  = 1'b1;
                        faddr_d = pend_q;
                    end else begin
                        instr_d = imem_rdata;
                        ipc_d   = faddr_q;
                        state_d = S_VALID;
                    end
                end else if (redirect_valid) begin
                    // Request stays on the bus untouched; its data is discarded on ack.
                    drop_d = 1'b1;
                    pend_d = redirect_pc;
                end
            end
            S_VALID: begin
                if (redirect_valid) begin
                    launch  = 1'b1;
                    faddr_d = redirect_pc;
                end else if (instr_ready) begin
                    launch  = 1'b1;
                    faddr_d = ipc_q + PC_INCR;
                end
            end
            S_FAULT: begin
                if (redirect_valid) begin
                    launch  = 1'b1;
                    faddr_d = redirect_pc;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (launch) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
            state_d = (faddr_d[1:0] != 2'b00) ? S_FAULT : S_FETCH;
`else
            state_d = S_FETCH;
`endif
        end
    end

    always_comb begin
        pc_en   = 1'b0;
        pc_next = faddr_q;
        if (redirect_valid) begin
            pc_en   = 1'b1;
            pc_next = redirect_pc;
        end else if (state_q == S_VALID && instr_ready) begin
            pc_en   = 1'b1;
            pc_next = ipc_q + PC_INCR;
        end
        if (reset) begin
            pc_en   = 1'b0;
            pc_next = RESET_PC;
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = faddr_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = (state_q == S_VALID);
`ifdef IFETCH_MISALIGN_CHECK_EN
    assign fetch_fault = (state_q == S_FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed and randomized checks of ifetch against an address-stream reference model.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_fail   = 0;

    ifetch #(.RESET_PC(32'h00000000)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_next(pc_next), .pc_en(pc_en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        step(); step();
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL reset_pc_en: got %b want 0", pc_en); end
        n_checks++; if (pc_next !== 32'h0) begin n_fail++; $display("FAIL reset_pc_next: got %h want 0", pc_next); end
        n_checks++; if (instr !== 32'h00000013) begin n_fail++; $display("FAIL reset_instr: got %h want 00000013", instr); end
        n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
    endtask

    task automatic test_basic();
        step();
        reset = 1'b0;
        step();
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        step();
        imem_ack = 1'b1; imem_rdata = 32'h00500093;
        step();
        imem_ack = 1'b0; instr_ready = 1'b1;
        #1;
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h00500093 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL basic_instr: got v=%b instr=%h pc=%h want 1/00500093/0", instr_valid, instr, instr_pc); end
        n_checks++; if (pc_en !== 1'b1 || pc_next !== 32'h4) begin n_fail++; $display("FAIL basic_pc_next: got en=%b next=%h want 1/4", pc_en, pc_next); end
        step();
        instr_ready = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL basic_next_req: got req=%b addr=%h want 1/4", imem_req, imem_addr); end
    endtask

    task automatic test_stall();
        imem_ack = 1'b1; imem_rdata = 32'h11111111;
        step();
        imem_ack = 1'b0; instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (instr_valid !== 1'b1 || instr !== 32'h11111111 || imem_req !== 1'b0 || pc_en !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v=%b instr=%h req=%b en=%b want 1/11111111/0/0", i, instr_valid, instr, imem_req, pc_en);
            end
            step();
        end
        instr_ready = 1'b1;
        #1;
        n_checks++; if (pc_en !== 1'b1 || pc_next !== 32'h8) begin n_fail++; $display("FAIL stall_release: got en=%b next=%h want 1/8", pc_en, pc_next); end
        step();
        instr_ready = 1'b0;
    endtask

    task automatic test_drop();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1;
        n_checks++; if (pc_en !== 1'b1 || pc_next !== 32'h40 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL drop_redirect: got en=%b next=%h addr=%h want 1/40/8", pc_en, pc_next, imem_addr); end
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL drop_hold1: got req=%b addr=%h want 1/8", imem_req, imem_addr); end
        step();
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL drop_hold2: got req=%b addr=%h want 1/8", imem_req, imem_addr); end
        step();
        imem_ack = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL drop_relaunch: got req=%b addr=%h v=%b want 1/40/0", imem_req, imem_addr, instr_valid); end
        imem_ack = 1'b1; imem_rdata = 32'h40404040;
        step();
        imem_ack = 1'b0;
        #1;
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'h40404040) begin n_fail++; $display("FAIL drop_deliver: got v=%b pc=%h instr=%h want 1/40/40404040", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_ready_redirect();
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        step();
        redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h20202020;
        step();
        imem_ack = 1'b0;
        #1;
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h20) begin n_fail++; $display("FAIL rr_setup: got v=%b pc=%h want 1/20", instr_valid, instr_pc); end
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        n_checks++; if (pc_en !== 1'b1 || pc_next !== 32'h100) begin n_fail++; $display("FAIL rr_priority: got en=%b next=%h want 1/100", pc_en, pc_next); end
        step();
        instr_ready = 1'b0; redirect_valid = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rr_next_addr: got req=%b addr=%h v=%b want 1/100/0", imem_req, imem_addr, instr_valid); end
    endtask

    task automatic test_wrap();
        imem_ack = 1'b1; imem_rdata = 32'h01010101;
        step();
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
        step();
        redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCAFEF00D;
        step();
        imem_ack = 1'b0; instr_ready = 1'b1;
        #1;
        n_checks++; if (instr_pc !== 32'hFFFFFFFC || pc_en !== 1'b1 || pc_next !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_next: got pc=%h en=%b next=%h want fffffffc/1/0", instr_pc, pc_en, pc_next); end
        step();
        instr_ready = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    endtask

`ifdef IFETCH_MISALIGN_CHECK_EN
    task automatic test_misalign();
        imem_ack = 1'b1; imem_rdata = 32'h0;
        step();
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h102;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (imem_req !== 1'b0 || fetch_fault !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL misalign_fault[%0d]: got req=%b fault=%b v=%b want 0/1/0", i, imem_req, fetch_fault, instr_valid); end
            step();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h104;
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h104) begin n_fail++; $display("FAIL misalign_clear: got fault=%b req=%b addr=%h want 0/1/104", fetch_fault, imem_req, imem_addr); end
    endtask
`endif

    task automatic test_async_reset();
        #1;
        reset = 1'b1; pc = 32'h0;
        #1;
        n_checks++; if (imem_req !== 1'b0 || pc_en !== 1'b0 || pc_next !== 32'h0 || instr !== 32'h00000013 || instr_pc !== 32'h0 || instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got req=%b en=%b next=%h instr=%h ipc=%h v=%b fault=%b", imem_req, pc_en, pc_next, instr, instr_pc, instr_valid, fetch_fault);
        end
        step(); step();
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0BAD0;
        step();
        imem_ack = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL async_restart: got req=%b addr=%h v=%b want 1/0/0", imem_req, imem_addr, instr_valid); end
    endtask

    task automatic test_random();
        logic [31:0] exp_addr, req_addr;
        logic        busy, exp_en;
        int          lat, deliveries, quiet;
        reset = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; pc = 32'h0;
        step(); step();
        reset = 1'b0;
        exp_addr = 32'h0; req_addr = 32'h0; busy = 1'b0; lat = 0; deliveries = 0; quiet = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            instr_ready    = ($urandom_range(0, 9) < 6);
            imem_ack       = 1'b0;
            imem_rdata     = $urandom;
            if (imem_req) begin
                if (!busy) begin
                    busy = 1'b1; lat = $urandom_range(0, 3); req_addr = imem_addr;
                end else begin
                    n_checks++; if (imem_addr !== req_addr) begin n_fail++; $display("FAIL rnd_addr_stable: got %h want %h", imem_addr, req_addr); end
                end
                if (lat == 0) begin
                    imem_ack = 1'b1; imem_rdata = memf(req_addr); busy = 1'b0;
                end else begin
                    lat--;
                end
            end
            #1;
            exp_en = redirect_valid || (instr_valid && instr_ready);
            n_checks++; if (pc_en !== exp_en) begin n_fail++; $display("FAIL rnd_pc_en: got %b want %b", pc_en, exp_en); end
            if (redirect_valid) begin
                n_checks++; if (pc_next !== redirect_pc) begin n_fail++; $display("FAIL rnd_pc_next_redir: got %h want %h", pc_next, redirect_pc); end
                exp_addr = redirect_pc;
                quiet = 0;
            end else if (instr_valid && instr_ready) begin
                n_checks++; if (instr_pc !== exp_addr || instr !== memf(exp_addr)) begin n_fail++; $display("FAIL rnd_deliver: got pc=%h instr=%h want %h/%h", instr_pc, instr, exp_addr, memf(exp_addr)); end
                n_checks++; if (pc_next !== exp_addr + 32'd4) begin n_fail++; $display("FAIL rnd_pc_next_seq: got %h want %h", pc_next, exp_addr + 32'd4); end
                exp_addr = exp_addr + 32'd4;
                deliveries++;
                quiet = 0;
            end else begin
                quiet++;
            end
            if (quiet > 40) begin
                n_checks++; n_fail++;
                $display("FAIL rnd_progress: got no delivery for %0d cycles want <= 40", quiet);
                break;
            end
            if (pc_en) pc = pc_next;
            step();
        end
        redirect_valid = 1'b0; instr_ready = 1'b0; imem_ack = 1'b0;
        n_checks++; if (deliveries < 100) begin n_fail++; $display("FAIL rnd_throughput: got %0d deliveries want >= 100", deliveries); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_drop();
        test_ready_redirect();
        test_wrap();
`ifdef IFETCH_MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
